// File: rtl/nonce_hub.sv
// Multi-channel golden-nonce collector: per-channel pending registers, round-robin
// arbitration into a FIFO, and a send/busy handshake towards the serial TX core.
module nonce_hub #(
  parameter int SLAVES       = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int CNT_W        = 8,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic [32*SLAVES-1:0]          slave_nonces,
  input  logic [SLAVES-1:0]             new_nonces,
  input  logic                          serial_busy,
  output logic [31:0]                   golden_nonce,
  output logic                          serial_send,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]              drop_count,
  output logic                          nonce_seen
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} tx_state_t;

  tx_state_t         state;
  logic [SLAVES-1:0] pend_valid;
  logic [31:0]       pend_data [SLAVES];
  logic [31:0]       fifo_mem  [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [PW-1:0]     arb_ptr;
  logic [TW-1:0]     timer;

  logic              grant_vld;
  logic [PW-1:0]     grant_idx;
  logic [SLAVES-1:0] grant_oh, load, drop;
  logic [CNT_W-1:0]  drop_next;
  logic              push, pop;

  // Round-robin search starting at arb_ptr; the full check uses the registered count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!flush && (int'(fifo_count) < FIFO_DEPTH)) begin
      for (int k = 0; k < SLAVES; k++) begin
        if (!grant_vld && pend_valid[(int'(arb_ptr) + k) % SLAVES]) begin
          grant_vld = 1'b1;
          grant_idx = PW'((int'(arb_ptr) + k) % SLAVES);
        end
      end
    end
  end

  // A strobe on a channel still holding an ungranted nonce is a drop; otherwise it loads.
  always_comb begin
    grant_oh  = '0;
    load      = '0;
    drop      = '0;
    drop_next = drop_count;
    for (int i = 0; i < SLAVES; i++) begin
      grant_oh[i] = grant_vld && (int'(grant_idx) == i);
      if (!flush && new_nonces[i]) begin
        if (pend_valid[i] && !grant_oh[i]) drop[i] = 1'b1;
        else                                load[i] = 1'b1;
      end
      if (drop[i] && (drop_next != '1)) drop_next = drop_next + CNT_W'(1);
    end
  end

  assign push = grant_vld;
  assign pop  = (state == IDLE) && (fifo_count != '0) && !serial_busy && !flush;

  // NOTE: data storage carries no reset; validity lives in pend_valid and fifo_count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SLAVES; i++) begin
      if (load[i]) pend_data[i] <= slave_nonces[32*i +: 32];
    end
    if (push) fifo_mem[wr_ptr] <= pend_data[grant_idx];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_valid   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      arb_ptr      <= '0;
      drop_count   <= '0;
      nonce_seen   <= 1'b0;
      golden_nonce <= '0;
      serial_send  <= 1'b0;
      timer        <= '0;
      state        <= IDLE;
    end else begin
      nonce_seen <= (|new_nonces) && !flush;
      drop_count <= drop_next;

      if (flush) begin
        pend_valid <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        pend_valid <= (pend_valid & ~grant_oh) | load;
        if (push) begin
          wr_ptr  <= wr_ptr + AW'(1);
          arb_ptr <= (int'(grant_idx) == SLAVES - 1) ? '0 : grant_idx + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      fifo_count <= fifo_count + CW'(1);
        else if (pop && !push) fifo_count <= fifo_count - CW'(1);
      end

      // TX handshake; flush never disturbs a word already handed to the TX core.
      case (state)
        IDLE: begin
          if (pop) begin
            golden_nonce <= fifo_mem[rd_ptr];
            serial_send  <= 1'b1;
            state        <= SEND;
          end
        end
        SEND: begin
          serial_send <= 1'b0;
          timer       <= '0;
          state       <= WAIT_HI;
        end
        WAIT_HI: begin
          if (serial_busy)                         state <= WAIT_LO;
          else if (timer == TW'(BUSY_TIMEOUT - 1)) state <= IDLE;
          else                                     timer <= timer + TW'(1);
        end
        WAIT_LO: begin
          if (!serial_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_hub.sv
// Self-checking bench for nonce_hub: directed tables and sequences plus randomized
// traffic compared every cycle against a queue-based reference model.
module tb_nonce_hub;

  localparam int SLAVES       = 4;
  localparam int FIFO_DEPTH   = 8;
  localparam int CNT_W        = 8;
  localparam int BUSY_TIMEOUT = 64;
  localparam int MAXD         = (1 << CNT_W) - 1;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic                        flush;
  logic [32*SLAVES-1:0]        slave_nonces;
  logic [SLAVES-1:0]           new_nonces;
  logic                        serial_busy;
  logic [31:0]                 golden_nonce;
  logic                        serial_send;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [CNT_W-1:0]            drop_count;
  logic                        nonce_seen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nonce_hub #(
    .SLAVES(SLAVES), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .slave_nonces(slave_nonces),
    .new_nonces(new_nonces), .serial_busy(serial_busy), .golden_nonce(golden_nonce),
    .serial_send(serial_send), .fifo_count(fifo_count), .drop_count(drop_count),
    .nonce_seen(nonce_seen)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending slots as arrays, FIFO as a queue, TX as a phase number.
  bit          m_pv [SLAVES];
  logic [31:0] m_pd [SLAVES];
  logic [31:0] m_fifo [$];
  int          m_ptr, m_tx, m_timer, m_drop;
  logic [31:0] m_gold;
  bit          m_send, m_seen;

  function automatic void model_step();
    int g;
    int n0;
    bit pop_now;
    if (!reset_n) begin
      foreach (m_pv[i]) m_pv[i] = 1'b0;
      m_fifo.delete();
      m_ptr = 0; m_tx = 0; m_timer = 0; m_drop = 0;
      m_gold = '0; m_send = 1'b0; m_seen = 1'b0;
      return;
    end
    n0      = m_fifo.size();
    g       = -1;
    m_seen  = (new_nonces != '0) && !flush;
    pop_now = (m_tx == 0) && (n0 > 0) && !serial_busy && !flush;
    if (!flush && n0 < FIFO_DEPTH)
      for (int k = 0; k < SLAVES; k++)
        if (g < 0 && m_pv[(m_ptr + k) % SLAVES]) g = (m_ptr + k) % SLAVES;
    if (flush) begin
      foreach (m_pv[i]) m_pv[i] = 1'b0;
      m_fifo.delete();
    end else begin
      for (int i = 0; i < SLAVES; i++)
        if (new_nonces[i] && m_pv[i] && i != g && m_drop < MAXD) m_drop++;
      if (pop_now) m_gold = m_fifo.pop_front();
      if (g >= 0) begin
        m_fifo.push_back(m_pd[g]);
        m_pv[g] = 1'b0;
        m_ptr   = (g + 1) % SLAVES;
      end
      for (int i = 0; i < SLAVES; i++)
        if (new_nonces[i] && !m_pv[i]) begin
          m_pd[i] = slave_nonces[32*i +: 32];
          m_pv[i] = 1'b1;
        end
    end
    m_send = 1'b0;
    case (m_tx)
      0: if (pop_now) begin m_tx = 1; m_send = 1'b1; end
      1: begin m_tx = 2; m_timer = 0; end
      2: if (serial_busy) m_tx = 3;
         else if (m_timer == BUSY_TIMEOUT - 1) m_tx = 0;
         else m_timer++;
      default: if (!serial_busy) m_tx = 0;
    endcase
  endfunction

  // One clock: DUT and model consume the same inputs, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("m_send",  serial_send,  m_send);
    check("m_gold",  golden_nonce, m_gold);
    check("m_count", fifo_count,   m_fifo.size());
    check("m_drop",  drop_count,   m_drop);
    check("m_seen",  nonce_seen,   m_seen);
    new_nonces = '0;
    flush      = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; flush = 1'b0; new_nonces = '0; serial_busy = 1'b0; slave_nonces = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_send(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      step();
      if (serial_send) ok = 1'b1;
    end
    check("wait_send", ok, 1'b1);
  endtask

  logic [31:0] got_q [$];

  task automatic drain(input int n, input int hold);
    bit ok;
    got_q.delete();
    for (int w = 0; w < n; w++) begin
      wait_send(40, ok);
      if (!ok) return;
      got_q.push_back(golden_nonce);
      serial_busy = 1'b1;
      repeat (hold) step();
      serial_busy = 1'b0;
      step();
    end
  endtask

  typedef struct {
    logic [SLAVES-1:0] nn;
    logic [31:0]       d2;
    logic              busy;
    logic              e_send;
    logic [31:0]       e_gold;
    int                e_cnt;
    logic              e_seen;
  } vec_t;

  initial begin
    vec_t        tbl [6];
    logic [31:0] exp_q [$];
    bit          ok;
    bit          found;
    int          gap, sends, dens;

    tbl[0] = '{4'b0100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        0, 1'b1};
    tbl[1] = '{4'b0000, 32'h0,        1'b0, 1'b0, 32'h0,        1, 1'b0};
    tbl[2] = '{4'b0000, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 0, 1'b0};
    tbl[3] = '{4'b0000, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 0, 1'b0};
    tbl[4] = '{4'b0000, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 0, 1'b0};
    tbl[5] = '{4'b0000, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 0, 1'b0};

    // Reset state
    do_reset();
    check("rst_send",  serial_send,  1'b0);
    check("rst_gold",  golden_nonce, 32'h0);
    check("rst_count", fifo_count,   0);
    check("rst_drop",  drop_count,   0);
    check("rst_seen",  nonce_seen,   1'b0);

    // Single nonce on ch2: send two edges after the strobe edge
    for (int i = 0; i < 6; i++) begin
      new_nonces          = tbl[i].nn;
      slave_nonces        = '0;
      slave_nonces[95:64] = tbl[i].d2;
      serial_busy         = tbl[i].busy;
      step();
      check($sformatf("tbl%0d_send", i),  serial_send,  tbl[i].e_send);
      check($sformatf("tbl%0d_gold", i),  golden_nonce, tbl[i].e_gold);
      check($sformatf("tbl%0d_count", i), fifo_count,   tbl[i].e_cnt);
      check($sformatf("tbl%0d_seen", i),  nonce_seen,   tbl[i].e_seen);
    end

    // Simultaneous strobes drain in channel order from pointer 0
    do_reset();
    new_nonces = 4'b1111;
    for (int i = 0; i < SLAVES; i++) slave_nonces[32*i +: 32] = 32'h10 + i;
    step();
    drain(4, 10);
    exp_q = '{32'h10, 32'h11, 32'h12, 32'h13};
    check("simul_n", got_q.size(), 4);
    foreach (got_q[i]) check($sformatf("simul_w%0d", i), got_q[i], exp_q[i]);

    // Fairness: ch0 hammered, ch3 strobed once, TX held off
    do_reset();
    serial_busy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      new_nonces = (k == 0) ? 4'b1001 : 4'b0001;
      slave_nonces[31:0]  = 32'h100 + k;
      slave_nonces[127:96] = 32'h300;
      step();
    end
    step();
    check("fair_count", fifo_count, 6);
    check("fair_drop",  drop_count, 1);
    serial_busy = 1'b0;
    drain(6, 3);
    exp_q = '{32'h100, 32'h300, 32'h101, 32'h103, 32'h104, 32'h105};
    check("fair_n", got_q.size(), 6);
    foreach (got_q[i]) check($sformatf("fair_w%0d", i), got_q[i], exp_q[i]);

    // Overflow with busy stuck high, then drop counter saturation
    do_reset();
    serial_busy = 1'b1;
    for (int k = 0; k < 14; k++) begin
      new_nonces = '0;
      new_nonces[k % SLAVES] = 1'b1;
      slave_nonces[32*(k % SLAVES) +: 32] = 32'h1000 + k;
      step();
    end
    check("ovf_count", fifo_count, 8);
    check("ovf_drop",  drop_count, 2);
    for (int k = 0; k < 75; k++) begin
      new_nonces = 4'b1111;
      step();
    end
    check("sat_drop",  drop_count, 255);
    check("sat_count", fifo_count, 8);

    // Flush while the TX core is mid-word (WAIT_LO)
    do_reset();
    new_nonces = 4'b0111;
    slave_nonces = {32'h0, 32'hA2, 32'hA1, 32'hA0};
    step();
    wait_send(10, ok);
    check("flush_first", golden_nonce, 32'hA0);
    serial_busy = 1'b1;
    step();
    step();
    flush = 1'b1;
    new_nonces = 4'b1000;
    slave_nonces[127:96] = 32'hB3;
    step();
    check("flush_count", fifo_count, 0);
    check("flush_drop",  drop_count, 0);
    check("flush_seen",  nonce_seen, 1'b0);
    serial_busy = 1'b0;
    step();
    sends = 0;
    repeat (20) begin
      step();
      if (serial_send) sends++;
    end
    check("flush_sends", sends, 0);
    check("flush_gold",  golden_nonce, 32'hA0);

    // Busy never rises: abandon after the timeout, then reset during SEND
    do_reset();
    new_nonces = 4'b1110;
    slave_nonces = {32'h77, 32'h66, 32'h55, 32'h0};
    step();
    wait_send(10, ok);
    check("to_first", golden_nonce, 32'h55);
    gap = 0;
    found = 1'b0;
    for (int n = 1; n <= 100 && !found; n++) begin
      step();
      if (serial_send) begin
        found = 1'b1;
        gap = n;
      end
    end
    check("to_gap",    gap, 66);
    check("to_second", golden_nonce, 32'h66);
    check("to_queued", fifo_count, 1);
    reset_n = 1'b0;
    step();
    check("rsend_send",  serial_send,  1'b0);
    check("rsend_count", fifo_count,   0);
    check("rsend_drop",  drop_count,   0);
    check("rsend_gold",  golden_nonce, 32'h0);
    reset_n = 1'b1;

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      dens = ((c / 500) % 2 == 1) ? 3 : 12;
      reset_n = ((c % 1000) != 999);
      flush = ($urandom_range(0, 150) == 0);
      if ($urandom_range(0, 2) == 0) serial_busy = ~serial_busy;
      for (int i = 0; i < SLAVES; i++) begin
        slave_nonces[32*i +: 32] = $urandom();
        new_nonces[i] = ($urandom_range(0, dens) == 0);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
